// File: rtl/spike_window_counter.sv
// Multi-channel windowed spike counter: counts per-channel spike events over a
// fixed window, then latches the counts and the argmax (winning) channel.
module spike_window_counter #(
   parameter  int NUM_INPUTS    = 1,
   parameter  int COUNTER_SIZE  = 4,
   parameter  int WINDOW_CYCLES = 16,
   parameter  int EDGE_DETECT   = 1,
   parameter  int SATURATE      = 1,
   parameter  int CONTINUOUS    = 0,
   localparam int IDX_W         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_INPUTS-1:0]              spike_in,
   input  logic                               start,
   input  logic                               abort,
   output logic                               busy,
   output logic                               count_valid,
   output logic [NUM_INPUTS*COUNTER_SIZE-1:0] counter_out,
   output logic [IDX_W-1:0]                   winner_idx,
   output logic                               winner_valid
);

   localparam int                WC_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WC_W-1:0]   WC_LAST = WC_W'(WINDOW_CYCLES - 1);
   localparam logic [COUNTER_SIZE-1:0] CNT_MAX = '1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                               state_q, state_d;
   logic [NUM_INPUTS-1:0]                spike_prev_q;
   logic [NUM_INPUTS-1:0]                ev;
   logic [COUNTER_SIZE-1:0]              live_q [NUM_INPUTS];
   logic [COUNTER_SIZE-1:0]              live_d [NUM_INPUTS];
   logic [COUNTER_SIZE-1:0]              sum    [NUM_INPUTS];
   logic [WC_W-1:0]                      wcnt_q, wcnt_d;
   logic [NUM_INPUTS*COUNTER_SIZE-1:0]   counter_out_q, counter_out_d, final_flat;
   logic [IDX_W-1:0]                     winner_idx_q, winner_idx_d, argmax;
   logic                                 winner_valid_q, winner_valid_d;
   logic                                 count_valid_q, count_valid_d;
   logic [COUNTER_SIZE-1:0]              best;
   logic                                 last_edge;

   // sum[] is the live count with this cycle's event folded in; at the last
   // edge it is the final window count, so the last sample is never lost.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_ch
         assign ev[gi]  = (EDGE_DETECT != 0) ? (spike_in[gi] & ~spike_prev_q[gi]) : spike_in[gi];
         assign sum[gi] = (ev[gi] && !((SATURATE != 0) && (live_q[gi] == CNT_MAX)))
                          ? live_q[gi] + 1'b1 : live_q[gi];
         assign final_flat[gi*COUNTER_SIZE +: COUNTER_SIZE] = sum[gi];
      end
   endgenerate

   // Strict '>' keeps the first (lowest) index on ties.
   always_comb begin
      argmax = '0;
      best   = sum[0];
      for (int i = 1; i < NUM_INPUTS; i++) begin
         if (sum[i] > best) begin
            best   = sum[i];
            argmax = IDX_W'(i);
         end
      end
   end

   assign last_edge = (wcnt_q == WC_LAST);

   always_comb begin
      state_d        = state_q;
      live_d         = live_q;
      wcnt_d         = wcnt_q;
      counter_out_d  = counter_out_q;
      winner_idx_d   = winner_idx_q;
      winner_valid_d = winner_valid_q;
      count_valid_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_RUN;
               wcnt_d  = '0;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               wcnt_d  = '0;
               for (int i = 0; i < NUM_INPUTS; i++) live_d[i] = '0;
            end else if (last_edge) begin
               counter_out_d  = final_flat;
               winner_idx_d   = argmax;
               winner_valid_d = |final_flat;
               count_valid_d  = 1'b1;
               wcnt_d         = '0;
               for (int i = 0; i < NUM_INPUTS; i++) live_d[i] = '0;
               state_d        = (CONTINUOUS != 0) ? S_RUN : S_IDLE;
            end else begin
               live_d = sum;
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         spike_prev_q   <= '0;
         wcnt_q         <= '0;
         counter_out_q  <= '0;
         winner_idx_q   <= '0;
         winner_valid_q <= 1'b0;
         count_valid_q  <= 1'b0;
         for (int i = 0; i < NUM_INPUTS; i++) live_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         spike_prev_q   <= spike_in;
         wcnt_q         <= wcnt_d;
         counter_out_q  <= counter_out_d;
         winner_idx_q   <= winner_idx_d;
         winner_valid_q <= winner_valid_d;
         count_valid_q  <= count_valid_d;
         live_q         <= live_d;
      end
   end

   assign busy         = (state_q == S_RUN);
   assign count_valid  = count_valid_q;
   assign counter_out  = counter_out_q;
   assign winner_idx   = winner_idx_q;
   assign winner_valid = winner_valid_q;

endmodule

// File: tb/tb_spike_window_counter.sv
// Directed bench for spike_window_counter: edge/level modes, saturation vs wrap,
// ties, abort, continuous windows and mid-window reset.
module tb_spike_window_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Unit A: N=4, W=16, edge mode, saturate, one-shot
   logic [3:0]  spk_a = '0;
   logic        start_a = 1'b0, abort_a = 1'b0;
   logic        busy_a, cv_a, wv_a;
   logic [15:0] cnt_a;
   logic [1:0]  idx_a;

   // Units B/C: N=4, W=32, level mode; B saturates, C wraps (shared inputs)
   logic [3:0]  spk_b = '0;
   logic        start_b = 1'b0, abort_b = 1'b0;
   logic        busy_b, cv_b, wv_b, busy_c, cv_c, wv_c;
   logic [15:0] cnt_b, cnt_c;
   logic [1:0]  idx_b, idx_c;

   // Unit D: N=4, W=16, edge mode, continuous
   logic [3:0]  spk_d = '0;
   logic        start_d = 1'b0, abort_d = 1'b0;
   logic        busy_d, cv_d, wv_d;
   logic [15:0] cnt_d;
   logic [1:0]  idx_d;

   spike_window_counter #(.NUM_INPUTS(4), .COUNTER_SIZE(4), .WINDOW_CYCLES(16),
      .EDGE_DETECT(1), .SATURATE(1), .CONTINUOUS(0)) u_a (
      .clk(clk), .rst(rst), .spike_in(spk_a), .start(start_a), .abort(abort_a),
      .busy(busy_a), .count_valid(cv_a), .counter_out(cnt_a),
      .winner_idx(idx_a), .winner_valid(wv_a));

   spike_window_counter #(.NUM_INPUTS(4), .COUNTER_SIZE(4), .WINDOW_CYCLES(32),
      .EDGE_DETECT(0), .SATURATE(1), .CONTINUOUS(0)) u_b (
      .clk(clk), .rst(rst), .spike_in(spk_b), .start(start_b), .abort(abort_b),
      .busy(busy_b), .count_valid(cv_b), .counter_out(cnt_b),
      .winner_idx(idx_b), .winner_valid(wv_b));

   spike_window_counter #(.NUM_INPUTS(4), .COUNTER_SIZE(4), .WINDOW_CYCLES(32),
      .EDGE_DETECT(0), .SATURATE(0), .CONTINUOUS(0)) u_c (
      .clk(clk), .rst(rst), .spike_in(spk_b), .start(start_b), .abort(abort_b),
      .busy(busy_c), .count_valid(cv_c), .counter_out(cnt_c),
      .winner_idx(idx_c), .winner_valid(wv_c));

   spike_window_counter #(.NUM_INPUTS(4), .COUNTER_SIZE(4), .WINDOW_CYCLES(16),
      .EDGE_DETECT(1), .SATURATE(1), .CONTINUOUS(1)) u_d (
      .clk(clk), .rst(rst), .spike_in(spk_d), .start(start_d), .abort(abort_d),
      .busy(busy_d), .count_valid(cv_d), .counter_out(cnt_d),
      .winner_idx(idx_d), .winner_valid(wv_d));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // m[c][j] = level of channel c at sampling edge j of the window
   typedef struct {
      string            name;
      logic [3:0][15:0] m;
      logic [15:0]      cnt;
      logic [1:0]       idx;
      logic             wv;
   } vec_t;

   vec_t vecs [4];

   task automatic run_win_a(input logic [3:0][15:0] m, output logic cv_early);
      cv_early = 1'b0;
      @(negedge clk); spk_a = '0; start_a = 1'b1;
      @(posedge clk); #1;
      chk("a_busy_after_start", busy_a, 1'b1);
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         start_a = 1'b0;
         for (int c = 0; c < 4; c++) spk_a[c] = m[c][j];
         @(posedge clk); #1;
         if (j < 15 && cv_a) cv_early = 1'b1;
      end
   endtask

   initial begin
      logic early;
      logic bad;

      vecs[0] = '{name: "edge_basic", m: {16'h0000, 16'hFFFF, 16'h0000, 16'h0222},
                  cnt: 16'h0103, idx: 2'd0, wv: 1'b1};
      vecs[1] = '{name: "tie_low_idx", m: {16'h0155, 16'h8001, 16'h5540, 16'h0003},
                  cnt: 16'h5251, idx: 2'd1, wv: 1'b1};
      vecs[2] = '{name: "no_spikes", m: {16'h0000, 16'h0000, 16'h0000, 16'h0000},
                  cnt: 16'h0000, idx: 2'd0, wv: 1'b0};
      vecs[3] = '{name: "last_sample", m: {16'h5555, 16'h0F00, 16'hFFFE, 16'h8000},
                  cnt: 16'h8111, idx: 2'd3, wv: 1'b1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_cv", cv_a, 1'b0);
      chk("rst_cnt", cnt_a, 16'h0);
      chk("rst_idx", idx_a, 2'd0);
      chk("rst_wv", wv_a, 1'b0);
      @(negedge clk); rst = 1'b0;

      // Table-driven edge-mode windows
      for (int v = 0; v < 4; v++) begin
         run_win_a(vecs[v].m, early);
         chk({vecs[v].name, "_cv_early"}, early, 1'b0);
         chk({vecs[v].name, "_cv"}, cv_a, 1'b1);
         chk({vecs[v].name, "_cnt"}, cnt_a, vecs[v].cnt);
         chk({vecs[v].name, "_idx"}, idx_a, vecs[v].idx);
         chk({vecs[v].name, "_wv"}, wv_a, vecs[v].wv);
         chk({vecs[v].name, "_busy_end"}, busy_a, 1'b0);
         @(negedge clk); spk_a = '0;
         @(posedge clk); #1;
         chk({vecs[v].name, "_cv_pulse"}, cv_a, 1'b0);
         chk({vecs[v].name, "_cnt_hold"}, cnt_a, vecs[v].cnt);
         $display("vector %s: counter_out=%h winner_idx=%0d winner_valid=%0d",
                  vecs[v].name, cnt_a, idx_a, wv_a);
      end

      // Level mode W=32: saturate (B) vs wrap (C)
      early = 1'b0;
      @(negedge clk); spk_b = '0; start_b = 1'b1;
      @(posedge clk); #1;
      chk("lvl_busy_after_start", busy_b, 1'b1);
      for (int j = 0; j < 32; j++) begin
         @(negedge clk);
         start_b  = 1'b0;
         spk_b[0] = (j < 5);
         spk_b[1] = 1'b1;
         spk_b[2] = (j < 20);
         spk_b[3] = 1'b0;
         @(posedge clk); #1;
         if (j < 31 && (cv_b || cv_c)) early = 1'b1;
      end
      chk("lvl_cv_early", early, 1'b0);
      chk("sat_cv", cv_b, 1'b1);
      chk("sat_cnt", cnt_b, 16'h0FF5);
      chk("sat_idx_tie", idx_b, 2'd1);
      chk("wrap_cv", cv_c, 1'b1);
      chk("wrap_cnt", cnt_c, 16'h0405);
      chk("wrap_idx", idx_c, 2'd0);
      chk("wrap_wv", wv_c, 1'b1);
      $display("level window: sat=%h wrap=%h", cnt_b, cnt_c);
      @(negedge clk); spk_b = '0;

      // Continuous mode: spike on last sample of window 1 and first of window 2
      bad = 1'b0;
      @(negedge clk); spk_d = '0; start_d = 1'b1;
      @(posedge clk); #1;
      for (int j = 0; j < 32; j++) begin
         @(negedge clk);
         start_d  = 1'b0;
         spk_d[0] = (j == 15);
         spk_d[1] = (j == 16);
         @(posedge clk); #1;
         if (j == 15) begin
            chk("cont_w1_cv", cv_d, 1'b1);
            chk("cont_w1_cnt", cnt_d, 16'h0001);
            chk("cont_w1_idx", idx_d, 2'd0);
            chk("cont_w1_busy", busy_d, 1'b1);
            $display("continuous window 1: counter_out=%h", cnt_d);
         end else if (j == 31) begin
            chk("cont_w2_cv", cv_d, 1'b1);
            chk("cont_w2_cnt", cnt_d, 16'h0010);
            chk("cont_w2_idx", idx_d, 2'd1);
            $display("continuous window 2: counter_out=%h", cnt_d);
         end else if (cv_d) begin
            bad = 1'b1;
         end
      end
      chk("cont_cv_spacing", bad, 1'b0);
      @(negedge clk); spk_d = '0; abort_d = 1'b1;
      @(posedge clk); #1;
      chk("cont_abort_busy", busy_d, 1'b0);
      @(negedge clk); abort_d = 1'b0;

      // Abort at sampling edge 8 of 16 keeps previous results
      @(negedge clk); spk_a = '0; start_a = 1'b1;
      @(posedge clk); #1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         start_a  = 1'b0;
         spk_a[0] = j[0];
         abort_a  = (j == 7);
         @(posedge clk); #1;
      end
      chk("abort_busy", busy_a, 1'b0);
      chk("abort_cnt_kept", cnt_a, 16'h8111);
      chk("abort_idx_kept", idx_a, 2'd3);
      bad = cv_a;
      @(negedge clk); abort_a = 1'b0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk); spk_a[0] = j[0];
         @(posedge clk); #1;
         if (cv_a || busy_a) bad = 1'b1;
      end
      chk("abort_no_cv", bad, 1'b0);
      $display("abort: busy=%0d counter_out=%h", busy_a, cnt_a);

      // start together with abort in IDLE: stays idle
      @(negedge clk); spk_a = '0; start_a = 1'b1; abort_a = 1'b1;
      @(posedge clk); #1;
      chk("start_abort_idle", busy_a, 1'b0);
      @(negedge clk); start_a = 1'b0; abort_a = 1'b0;

      // Restart after abort: live counts must have been cleared
      run_win_a(vecs[0].m, early);
      chk("restart_cv", cv_a, 1'b1);
      chk("restart_cnt", cnt_a, 16'h0103);
      $display("restart: counter_out=%h", cnt_a);

      // Reset mid-window with nonzero latched results
      @(negedge clk); spk_a = '0; start_a = 1'b1;
      @(posedge clk); #1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk); start_a = 1'b0; spk_a[0] = j[0];
         @(posedge clk); #1;
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", busy_a, 1'b0);
      chk("midrst_cv", cv_a, 1'b0);
      chk("midrst_cnt", cnt_a, 16'h0);
      chk("midrst_idx", idx_a, 2'd0);
      chk("midrst_wv", wv_a, 1'b0);
      @(negedge clk); rst = 1'b0;
      bad = 1'b0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk); spk_a[0] = j[0];
         @(posedge clk); #1;
         if (cv_a || busy_a) bad = 1'b1;
      end
      chk("midrst_idle_after", bad, 1'b0);
      $display("mid-window reset: busy=%0d counter_out=%h", busy_a, cnt_a);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
